// File: rtl/note_judge.sv
// Judges the hit-zone row of the falling-note matrix against synchronized key presses,
// producing per-lane hit/miss pulses plus saturating score, combo and max-combo counters.
module note_judge #(
    parameter int HIT_PTS = 10,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               game_active,
    input  logic               row_tick,
    input  logic [3:0]         judge_row,
    input  logic [3:0]         keys,
    output logic [3:0]         hit_pulse,
    output logic [3:0]         miss_pulse,
    output logic [3:0]         lane_clear,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo
);

    localparam int SUM_W = SCORE_W + 8;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t             state;
    logic [3:0]         sync1, sync2, sync3, kedge;
    logic [3:0]         consumed;
    logic [3:0]         pending, hits, misses;
    logic [2:0]         hit_cnt;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [8:0]         combo_sum;
    logic [7:0]         combo_next, max_next;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < 4; i++) cnt = cnt + 3'(v[i]);
        return cnt;
    endfunction

    // NOTE: every register in a clocked block uses <= so all stages read pre-edge values;
    // with = the synchronizer would collapse into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            kedge <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            sync3 <= sync2;
            kedge <= sync2 & ~sync3;
        end
    end

    // A key edge on the tick cycle still scores against the outgoing row.
    always_comb begin
        pending    = judge_row & ~consumed;
        hits       = kedge & pending;
        misses     = row_tick ? (pending & ~kedge) : 4'b0000;
        hit_cnt    = popcount4(hits);
        score_sum  = SUM_W'(score) + SUM_W'(HIT_PTS) * SUM_W'(hit_cnt);
        score_next = (|score_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        combo_sum  = {1'b0, combo} + {6'b000000, hit_cnt};
        if (|misses)
            combo_next = 8'd0;
        else if (combo_sum[8])
            combo_next = 8'hFF;
        else
            combo_next = combo_sum[7:0];
        max_next   = (combo_next > max_combo) ? combo_next : max_combo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            consumed   <= '0;
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
        end else begin
            hit_pulse  <= '0;
            miss_pulse <= '0;
            case (state)
                IDLE, DONE: begin
                    if (game_active) begin
                        state     <= PLAY;
                        consumed  <= '0;
                        score     <= '0;
                        combo     <= '0;
                        max_combo <= '0;
                    end
                end
                PLAY: begin
                    // Leaving play abandons the open window: no misses, results frozen.
                    if (!game_active) begin
                        state    <= DONE;
                        consumed <= '0;
                    end else begin
                        hit_pulse  <= hits;
                        miss_pulse <= misses;
                        consumed   <= row_tick ? 4'b0000 : (consumed | hits);
                        score      <= score_next;
                        combo      <= combo_next;
                        max_combo  <= max_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lane_clear = consumed;

endmodule

// File: tb/tb_note_judge.sv
// Self-checking bench for note_judge: directed table, hand-written corner sequences and
// randomized play, all compared against a cycle-level behavioural model of the game rules.
module tb_note_judge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        game_active, row_tick;
    logic [3:0]  judge_row, keys;

    logic [3:0]  hit_pulse, miss_pulse, lane_clear;
    logic [15:0] score;
    logic [7:0]  combo, max_combo;
    logic [3:0]  hit8, miss8, clr8;
    logic [7:0]  score8, combo8, max8;

    note_judge dut (
        .clk(clk), .rst_n(rst_n), .game_active(game_active), .row_tick(row_tick),
        .judge_row(judge_row), .keys(keys), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .lane_clear(lane_clear), .score(score), .combo(combo), .max_combo(max_combo)
    );

    note_judge #(.HIT_PTS(10), .SCORE_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .game_active(game_active), .row_tick(row_tick),
        .judge_row(judge_row), .keys(keys), .hit_pulse(hit8), .miss_pulse(miss8),
        .lane_clear(clr8), .score(score8), .combo(combo8), .max_combo(max8)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, name, act, exp, $time);
        end
    endtask

    // Behavioural model: game rules expressed on integers and lane loops.
    bit         m_play;
    logic [3:0] m_cons, m_hit, m_miss;
    int         m_score, m_combo, m_max;
    logic [3:0] m_hist [4];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_play = 0; m_cons = '0; m_hit = '0; m_miss = '0;
        m_score = 0; m_combo = 0; m_max = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
    endtask

    // Called at each rising edge; a key seen high at edge E-3 and low at E-4 is a press
    // that the judge acts on at edge E.
    task automatic model_edge();
        logic [3:0] ked;
        int         nh;
        ked = m_hist[2] & ~m_hist[3];
        m_hit = '0; m_miss = '0;
        if (!m_play) begin
            if (game_active) begin
                m_play = 1; m_score = 0; m_combo = 0; m_max = 0; m_cons = '0;
            end
        end else if (!game_active) begin
            m_play = 0; m_cons = '0;
        end else begin
            nh = 0;
            for (int l = 0; l < 4; l++) begin
                if (judge_row[l] && !m_cons[l]) begin
                    if (ked[l]) begin m_hit[l] = 1'b1; nh++; end
                    else if (row_tick) m_miss[l] = 1'b1;
                end
            end
            m_score += 10 * nh;
            m_combo = (m_miss != 0) ? 0 : sat(m_combo + nh, 255);
            if (m_combo > m_max) m_max = m_combo;
            m_cons = row_tick ? 4'b0000 : (m_cons | m_hit);
        end
        m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = keys;
    endtask

    task automatic compare_all();
        check("hit_pulse",  hit_pulse,  m_hit);
        check("miss_pulse", miss_pulse, m_miss);
        check("lane_clear", lane_clear, m_cons);
        check("score",      score,      sat(m_score, 65535));
        check("combo",      combo,      m_combo);
        check("max_combo",  max_combo,  m_max);
        check("score8",     score8,     sat(m_score, 255));
        check("combo8",     combo8,     m_combo);
    endtask

    task automatic step(input logic ga, input logic rt, input logic [3:0] jr, input logic [3:0] k);
        @(negedge clk);
        game_active = ga; row_tick = rt; judge_row = jr; keys = k;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Press pattern p now; the judged edge lands on the fourth step (this one plus three).
    task automatic press_and_judge(input logic [3:0] jr, input logic [3:0] p, input logic tick_on_hit);
        step(1'b1, 1'b0, jr, p);
        step(1'b1, 1'b0, jr, 4'b0000);
        step(1'b1, 1'b0, jr, 4'b0000);
        step(1'b1, tick_on_hit, jr, 4'b0000);
    endtask

    typedef struct {
        logic       ga, rt;
        logic [3:0] jr, k, hit, miss, clr;
        int         sc, cb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,  0};
        tbl[1] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0,  0};
        tbl[2] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0,  0};
        tbl[3] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0,  0};
        tbl[4] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 10, 1};
        tbl[5] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 10, 1};
        tbl[6] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10, 1};
        tbl[7] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10, 1};
        tbl[8] = '{1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 10, 0};
        tbl[9] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10, 0};

        rst_n = 1'b0; game_active = 1'b0; row_tick = 1'b0; judge_row = '0; keys = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        phase = "table";
        foreach (tbl[i]) begin
            step(tbl[i].ga, tbl[i].rt, tbl[i].jr, tbl[i].k);
            check("tbl_hit",   hit_pulse,  tbl[i].hit);
            check("tbl_miss",  miss_pulse, tbl[i].miss);
            check("tbl_clear", lane_clear, tbl[i].clr);
            check("tbl_score", score,      tbl[i].sc);
            check("tbl_combo", combo,      tbl[i].cb);
        end

        phase = "all_lanes";
        press_and_judge(4'b1111, 4'b1111, 1'b0);
        check("hit_all", hit_pulse, 4'b1111);
        check("score_all", score, 50);
        check("combo_all", combo, 4);
        press_and_judge(4'b1111, 4'b0001, 1'b0);
        check("repress_hit", hit_pulse, 4'b0000);
        check("repress_score", score, 50);
        step(1'b1, 1'b1, 4'b1111, 4'b0000);
        check("consumed_no_miss", miss_pulse, 4'b0000);

        phase = "tick_align";
        press_and_judge(4'b0110, 4'b0100, 1'b1);
        check("aligned_hit", hit_pulse, 4'b0100);
        check("aligned_miss", miss_pulse, 4'b0010);
        check("aligned_combo", combo, 0);
        check("aligned_max", max_combo, 4);
        check("aligned_clear", lane_clear, 4'b0000);
        step(1'b1, 1'b0, 4'b0000, 4'b0000);

        phase = "saturate";
        for (int i = 0; i < 80; i++) begin
            step(1'b1, i > 0, 4'b1111, 4'b1111);
            step(1'b1, 1'b0, 4'b1111, 4'b0000);
            step(1'b1, 1'b0, 4'b1111, 4'b0000);
            step(1'b1, 1'b0, 4'b1111, 4'b0000);
        end
        check("sat_score16", score, 3260);
        check("sat_score8", score8, 255);
        check("sat_combo", combo, 255);
        check("sat_max", max_combo, 255);

        phase = "game_end";
        step(1'b1, 1'b1, 4'b1111, 4'b0000);
        step(1'b1, 1'b0, 4'b0010, 4'b0000);
        step(1'b0, 1'b1, 4'b0010, 4'b0000);
        check("end_no_miss", miss_pulse, 4'b0000);
        check("end_score", score, 3260);
        step(1'b0, 1'b0, 4'b0001, 4'b0001);
        repeat (4) step(1'b0, 1'b0, 4'b0001, 4'b0000);
        check("done_score_held", score, 3260);
        check("done_combo_held", combo, 255);
        step(1'b1, 1'b0, 4'b0000, 4'b0000);
        check("restart_score", score, 0);
        check("restart_combo", combo, 0);
        check("restart_max", max_combo, 0);
        press_and_judge(4'b0001, 4'b0001, 1'b0);
        check("replay_score", score, 10);

        phase = "async_reset";
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_score", score, 0);
        check("rst_clear", lane_clear, 4'b0000);
        check("rst_max", max_combo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "random";
        begin
            logic [3:0] jr;
            logic       rt;
            logic       prev_rt;
            jr = 4'($urandom);
            prev_rt = 1'b0;
            for (int n = 0; n < 2000; n++) begin
                if (prev_rt) jr = 4'($urandom);
                rt = ($urandom_range(0, 3) == 0);
                step($urandom_range(0, 49) != 0, rt, jr, 4'($urandom));
                prev_rt = rt;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
